ucsbece154a_mcontroller: RTL and testbench

- Multicycle control FSM for the RV32I subset the processor supports: lw, sw, R-type, I-type ALU, beq, jal, lui.
- Sequences the shared-memory, single-ALU multicycle datapath: selects the address source, IR/PC/register/memory write strobes, and ALU operand muxes each cycle.
- Decodes ImmSrc and ALUControl from the opcode in the instruction register and from funct3/funct7.
- Sits beside the multicycle datapath in the top level and replaces the single-cycle controller there.

---
 rtl/ucsbece154a_mcontroller_pkg.sv | 73 +++++++
 rtl/ucsbece154a_mcontroller_aludec.sv | 30 +++
 rtl/ucsbece154a_mcontroller.sv | 155 +++++++++++++++
 tb/tb_ucsbece154a_mcontroller.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154a_mcontroller_pkg.sv
// Shared state encodings, opcode/funct3 constants and mux select codes for the
// multicycle controller and its ALU decoder.
package ucsbece154a_mcontroller_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10,
        StLui      = 4'd11,
        StError    = 4'd15
    } state_e;

    typedef enum logic [1:0] {
        AluOpMem   = 2'b00,
        AluOpBeq   = 2'b01,
        AluOpOther = 2'b10
    } alu_op_e;

    localparam logic [6:0] OpLw    = 7'b0000011;
    localparam logic [6:0] OpSw    = 7'b0100011;
    localparam logic [6:0] OpRtype = 7'b0110011;
    localparam logic [6:0] OpItype = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpLui   = 7'b0110111;

    localparam logic [2:0] Funct3AddSub = 3'b000;
    localparam logic [2:0] Funct3Slt    = 3'b010;
    localparam logic [2:0] Funct3Or     = 3'b110;
    localparam logic [2:0] Funct3And    = 3'b111;

    localparam logic [2:0] AluCtlAdd = 3'b000;
    localparam logic [2:0] AluCtlSub = 3'b001;
    localparam logic [2:0] AluCtlSlt = 3'b010;
    localparam logic [2:0] AluCtlOr  = 3'b011;
    localparam logic [2:0] AluCtlAnd = 3'b100;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    localparam logic [1:0] SrcAPc     = 2'b00;
    localparam logic [1:0] SrcAOldPc  = 2'b01;
    localparam logic [1:0] SrcARd1    = 2'b10;
    localparam logic [1:0] SrcAZero   = 2'b11;
    localparam logic [1:0] SrcBRd2    = 2'b00;
    localparam logic [1:0] SrcBImm    = 2'b01;
    localparam logic [1:0] SrcBFour   = 2'b10;
    localparam logic [1:0] ResAluOut  = 2'b00;
    localparam logic [1:0] ResData    = 2'b01;
    localparam logic [1:0] ResAluRslt = 2'b10;

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        unique case (op)
            OpSw:    return ImmS;
            OpBeq:   return ImmB;
            OpJal:   return ImmJ;
            OpLui:   return ImmU;
            default: return ImmI;
        endcase
    endfunction

endpackage

// File: rtl/ucsbece154a_mcontroller_aludec.sv
// Combinational ALU decoder: ALUOp plus funct3/funct7b5/op[5] to ALUControl.
module ucsbece154a_mcontroller_aludec
    import ucsbece154a_mcontroller_pkg::*;
(
    input  alu_op_e    alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = AluCtlAdd;
        unique case (alu_op_i)
            AluOpMem: alu_control_o = AluCtlAdd;
            AluOpBeq: alu_control_o = AluCtlSub;
            default: begin
                unique case (funct3_i)
                    // addi never subtracts even when instr[30] happens to be set
                    Funct3AddSub: alu_control_o = (funct7b5_i & op5_i) ? AluCtlSub : AluCtlAdd;
                    Funct3Slt:    alu_control_o = AluCtlSlt;
                    Funct3Or:     alu_control_o = AluCtlOr;
                    Funct3And:    alu_control_o = AluCtlAnd;
                    default:      alu_control_o = AluCtlAdd;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/ucsbece154a_mcontroller.sv
// Multicycle RV32I control FSM (lw, sw, R, I-ALU, beq, jal, lui).
// Define UCSBECE154A_MEM_READY_EN to add mem_ready_i wait states on memory accesses.
module ucsbece154a_mcontroller
    import ucsbece154a_mcontroller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
`ifdef UCSBECE154A_MEM_READY_EN
    input  logic       mem_ready_i,
`endif
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    output logic       PCWrite_o,
    output logic       AdrSrc_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic [1:0] ResultSrc_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic       RegWrite_o,
    output logic [2:0] ALUControl_o,
    output logic [2:0] ImmSrc_o,
    output logic       error_o,
    output logic [3:0] state_o
);

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    ready;
    logic    pc_update, branch, ir_write, mem_write, reg_write;

`ifdef UCSBECE154A_MEM_READY_EN
    assign ready = mem_ready_i;
`else
    assign ready = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StFetch;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    state_d = ready ? StDecode : StFetch;
            StDecode: begin
                unique case (op_i)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecuteR;
                    OpItype:    state_d = StExecuteI;
                    OpBeq:      state_d = StBeq;
                    OpJal:      state_d = StJal;
                    OpLui:      state_d = StLui;
                    default:    state_d = StError;
                endcase
            end
            StMemAdr:   state_d = (op_i == OpSw) ? StMemWrite : StMemRead;
            StMemRead:  state_d = ready ? StMemWb : StMemRead;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = ready ? StFetch : StMemWrite;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            StJal:      state_d = StAluWb;
            StLui:      state_d = StAluWb;
            StError:    state_d = StError;
            default:    state_d = StError;
        endcase
    end

    always_comb begin
        pc_update   = 1'b0;
        branch      = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        AdrSrc_o    = 1'b0;
        ResultSrc_o = ResAluOut;
        ALUSrcA_o   = SrcAPc;
        ALUSrcB_o   = SrcBRd2;
        alu_op      = AluOpMem;
        unique case (state_q)
            StFetch: begin
                ir_write    = ready;
                pc_update   = ready;
                ALUSrcB_o   = SrcBFour;
                ResultSrc_o = ResAluRslt;
            end
            StDecode: begin
                ALUSrcA_o = SrcAOldPc;
                ALUSrcB_o = SrcBImm;
            end
            StMemAdr: begin
                ALUSrcA_o = SrcARd1;
                ALUSrcB_o = SrcBImm;
            end
            StMemRead:  AdrSrc_o = 1'b1;
            StMemWb: begin
                ResultSrc_o = ResData;
                reg_write   = 1'b1;
            end
            StMemWrite: begin
                AdrSrc_o  = 1'b1;
                mem_write = 1'b1;
            end
            StExecuteR: begin
                ALUSrcA_o = SrcARd1;
                alu_op    = AluOpOther;
            end
            StExecuteI: begin
                ALUSrcA_o = SrcARd1;
                ALUSrcB_o = SrcBImm;
                alu_op    = AluOpOther;
            end
            StAluWb:    reg_write = 1'b1;
            StBeq: begin
                ALUSrcA_o = SrcARd1;
                alu_op    = AluOpBeq;
                branch    = 1'b1;
            end
            StJal: begin
                ALUSrcA_o = SrcAOldPc;
                ALUSrcB_o = SrcBFour;
                pc_update = 1'b1;
            end
            StLui: begin
                ALUSrcA_o = SrcAZero;
                ALUSrcB_o = SrcBImm;
            end
            default: ;
        endcase
    end

    ucsbece154a_mcontroller_aludec u_aludec (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3_i),
        .funct7b5_i    (funct7b5_i),
        .op5_i         (op_i[5]),
        .alu_control_o (ALUControl_o)
    );

    // Strobes are gated by reset directly so nothing writes while reset is held.
    assign PCWrite_o  = reset & (pc_update | (branch & zero_i));
    assign IRWrite_o  = reset & ir_write;
    assign MemWrite_o = reset & mem_write;
    assign RegWrite_o = reset & reg_write;
    assign error_o    = reset & (state_q == StError);
    assign ImmSrc_o   = imm_src(op_i);
    assign state_o    = state_q;

endmodule

// File: tb/tb_ucsbece154a_mcontroller.sv
// Directed self-checking bench for the multicycle controller.
module tb_ucsbece154a_mcontroller;

    logic       clk, reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, error;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;
    logic [3:0] state;
    logic [21:0] obs;
    int n_cmp, n_err;
`ifdef UCSBECE154A_MEM_READY_EN
    logic mem_ready;
`endif

    ucsbece154a_mcontroller dut (
        .clk          (clk),
        .reset        (reset),
`ifdef UCSBECE154A_MEM_READY_EN
        .mem_ready_i  (mem_ready),
`endif
        .op_i         (op),
        .funct3_i     (funct3),
        .funct7b5_i   (funct7b5),
        .zero_i       (zero),
        .PCWrite_o    (PCWrite),
        .AdrSrc_o     (AdrSrc),
        .MemWrite_o   (MemWrite),
        .IRWrite_o    (IRWrite),
        .ResultSrc_o  (ResultSrc),
        .ALUSrcA_o    (ALUSrcA),
        .ALUSrcB_o    (ALUSrcB),
        .RegWrite_o   (RegWrite),
        .ALUControl_o (ALUControl),
        .ImmSrc_o     (ImmSrc),
        .error_o      (error),
        .state_o      (state)
    );

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  RegWrite, ALUControl, ImmSrc, error, state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, want finish before 500000");
        $fatal(1);
    end

    function automatic logic [21:0] ev(input logic pcw, adr, mw, irw,
                                       input logic [1:0] rs, sa, sb, input logic rw,
                                       input logic [2:0] alu, imm, input logic err,
                                       input logic [3:0] st);
        return {pcw, adr, mw, irw, rs, sa, sb, rw, alu, imm, err, st};
    endfunction

    function automatic logic [21:0] fetch_v(input logic [2:0] imm);
        return ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 3'b000, imm, 0, 4'd0);
    endfunction

    function automatic logic [21:0] decode_v(input logic [2:0] imm);
        return ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000, imm, 0, 4'd1);
    endfunction

    function automatic logic [21:0] reset_v(input logic [2:0] imm);
        return ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 3'b000, imm, 0, 4'd0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        op = 7'b0000011;
        funct3 = 3'b000;
        funct7b5 = 1'b0;
        zero = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs !== reset_v(3'b000)) begin
                n_err++;
                $display("FAIL reset cyc %0d: got %b want %b", i, obs, reset_v(3'b000));
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== fetch_v(3'b000)) begin
            n_err++;
            $display("FAIL reset_release: got %b want %b", obs, fetch_v(3'b000));
        end
    endtask

    task automatic test_lw();
        logic [21:0] e [5];
        op = 7'b0000011;
        #1;
        e[0] = fetch_v(3'b000);
        e[1] = decode_v(3'b000);
        e[2] = ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 3'b000, 0, 4'd2);
        e[3] = ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 0, 4'd3);
        e[4] = ev(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000, 3'b000, 0, 4'd4);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            n_cmp++;
            if (obs !== e[i]) begin
                n_err++;
                $display("FAIL lw cyc %0d: got %b want %b", i, obs, e[i]);
            end
        end
        step();
        n_cmp++;
        if (state !== 4'd0) begin
            n_err++;
            $display("FAIL lw_end: got state %0d want 0", state);
        end
    endtask

    task automatic test_sw();
        logic [21:0] e [4];
        op = 7'b0100011;
        #1;
        e[0] = fetch_v(3'b001);
        e[1] = decode_v(3'b001);
        e[2] = ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 3'b001, 0, 4'd2);
        e[3] = ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b001, 0, 4'd5);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            n_cmp++;
            if (obs !== e[i]) begin
                n_err++;
                $display("FAIL sw cyc %0d: got %b want %b", i, obs, e[i]);
            end
        end
        step();
        n_cmp++;
        if (state !== 4'd0 || MemWrite !== 1'b0) begin
            n_err++;
            $display("FAIL sw_end: got state %0d memwrite %b want 0 0", state, MemWrite);
        end
    endtask

    task automatic test_beq(input logic z);
        logic [21:0] e [3];
        op = 7'b1100011;
        zero = z;
        #1;
        e[0] = fetch_v(3'b010);
        e[1] = decode_v(3'b010);
        e[2] = ev(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b001, 3'b010, 0, 4'd9);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            n_cmp++;
            if (obs !== e[i]) begin
                n_err++;
                $display("FAIL beq z=%b cyc %0d: got %b want %b", z, i, obs, e[i]);
            end
        end
        step();
        zero = 1'b0;
        n_cmp++;
        if (state !== 4'd0) begin
            n_err++;
            $display("FAIL beq_end: got state %0d want 0", state);
        end
    endtask

    // R/I ALU ops: {op, funct3, funct7b5, expected ALUControl}
    task automatic test_alu();
        logic [13:0] tbl [7];
        logic [6:0]  t_op;
        logic [2:0]  t_alu;
        logic [3:0]  ex_st;
        logic [1:0]  ex_sb;
        tbl[0] = {7'b0110011, 3'b000, 1'b1, 3'b001};
        tbl[1] = {7'b0010011, 3'b000, 1'b1, 3'b000};
        tbl[2] = {7'b0110011, 3'b000, 1'b0, 3'b000};
        tbl[3] = {7'b0110011, 3'b010, 1'b0, 3'b010};
        tbl[4] = {7'b0010011, 3'b110, 1'b0, 3'b011};
        tbl[5] = {7'b0110011, 3'b111, 1'b0, 3'b100};
        tbl[6] = {7'b0010011, 3'b001, 1'b0, 3'b000};
        for (int k = 0; k < 7; k++) begin
            t_op     = tbl[k][13:7];
            funct3   = tbl[k][6:4];
            funct7b5 = tbl[k][3];
            t_alu    = tbl[k][2:0];
            op       = t_op;
            ex_st    = t_op[5] ? 4'd6 : 4'd7;
            ex_sb    = t_op[5] ? 2'b00 : 2'b01;
            step();
            step();
            n_cmp++;
            if (obs !== ev(0, 0, 0, 0, 2'b00, 2'b10, ex_sb, 0, t_alu, 3'b000, 0, ex_st)) begin
                n_err++;
                $display("FAIL alu row %0d execute: got %b want %b", k, obs,
                         ev(0, 0, 0, 0, 2'b00, 2'b10, ex_sb, 0, t_alu, 3'b000, 0, ex_st));
            end
            step();
            n_cmp++;
            if (obs !== ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 3'b000, 0, 4'd8)) begin
                n_err++;
                $display("FAIL alu row %0d aluwb: got %b want state 8 regwrite 1", k, obs);
            end
            step();
        end
        funct3 = 3'b000;
        funct7b5 = 1'b0;
    endtask

    task automatic test_jal_lui();
        op = 7'b1101111;
        step();
        step();
        n_cmp++;
        if (obs !== ev(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b000, 3'b011, 0, 4'd10)) begin
            n_err++;
            $display("FAIL jal: got %b want %b", obs,
                     ev(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b000, 3'b011, 0, 4'd10));
        end
        step();
        n_cmp++;
        if (state !== 4'd8 || RegWrite !== 1'b1) begin
            n_err++;
            $display("FAIL jal_wb: got state %0d regwrite %b want 8 1", state, RegWrite);
        end
        step();
        op = 7'b0110111;
        step();
        step();
        n_cmp++;
        if (obs !== ev(0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 0, 3'b000, 3'b100, 0, 4'd11)) begin
            n_err++;
            $display("FAIL lui: got %b want %b", obs,
                     ev(0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 0, 3'b000, 3'b100, 0, 4'd11));
        end
        step();
        step();
        n_cmp++;
        if (state !== 4'd0) begin
            n_err++;
            $display("FAIL lui_end: got state %0d want 0", state);
        end
    endtask

    task automatic test_illegal();
        int bad;
        op = 7'b1111111;
        step();
        step();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (obs !== ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 1, 4'd15))
                bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL illegal_hold: got %0d bad cycles (last %b) want 0", bad, obs);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== reset_v(3'b000)) begin
            n_err++;
            $display("FAIL illegal_reset: got %b want %b", obs, reset_v(3'b000));
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (error !== 1'b0 || state !== 4'd0) begin
            n_err++;
            $display("FAIL illegal_clear: got error %b state %0d want 0 0", error, state);
        end
    endtask

    task automatic test_back_to_back_reset();
        op = 7'b0100011;
        step();
        step();
        step();
        n_cmp++;
        if (state !== 4'd5 || MemWrite !== 1'b1) begin
            n_err++;
            $display("FAIL async_pre: got state %0d memwrite %b want 5 1", state, MemWrite);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== reset_v(3'b001)) begin
            n_err++;
            $display("FAIL async_reset: got %b want %b", obs, reset_v(3'b001));
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

`ifdef UCSBECE154A_MEM_READY_EN
    task automatic test_mem_ready();
        op = 7'b0000011;
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            n_cmp++;
            if (obs !== reset_v(3'b000)) begin
                n_err++;
                $display("FAIL ready_wait cyc %0d: got %b want %b", i, obs, reset_v(3'b000));
            end
        end
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (obs !== fetch_v(3'b000)) begin
            n_err++;
            $display("FAIL ready_go: got %b want %b", obs, fetch_v(3'b000));
        end
        step();
        n_cmp++;
        if (state !== 4'd1) begin
            n_err++;
            $display("FAIL ready_decode: got state %0d want 1", state);
        end
        for (int i = 0; i < 4; i++) step();
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
`ifdef UCSBECE154A_MEM_READY_EN
        mem_ready = 1'b1;
`endif
        test_reset();
        test_lw();
        test_sw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_alu();
        test_jal_lui();
        test_illegal();
        test_back_to_back_reset();
`ifdef UCSBECE154A_MEM_READY_EN
        test_mem_ready();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
